// File: rtl/fetch_unit.sv
// Front-end fetch stage: sequential word-address generator for a 1-cycle-latency
// instruction BRAM, feeding {pc, instr} to the decode skid buffer via valid/ready.
module fetch_unit #(
    parameter int PC_W    = 9,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               cache_en,
    output logic [PC_W-1:0]    cache_pc,
    input  logic [INSTR_W-1:0] cache_instr,
    input  logic               skid_ready,
    output logic               fetch_valid,
    output logic [PC_W-1:0]    fetch_pc,
    output logic [INSTR_W-1:0] fetch_instr,
    output logic               pc_wrap,
    output logic [CNT_W-1:0]   fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] PC_MAX = {PC_W{1'b1}};

    logic [PC_W-1:0]  next_pc_q, next_pc_d;
    logic [PC_W-1:0]  req_pc_q, req_pc_d;
    logic             resp_valid_q, resp_valid_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
    state_t           state_q, state_d;
    logic             stall_s;

    // Output decode and next-state computation; reset forces the BRAM idle.
    always_comb begin
        stall_s       = resp_valid_q & ~skid_ready;
        cache_en      = 1'b0;
        cache_pc      = {PC_W{1'b0}};
        fetch_valid   = 1'b0;
        pc_wrap       = 1'b0;
        next_pc_d     = next_pc_q;
        req_pc_d      = req_pc_q;
        resp_valid_d  = resp_valid_q;
        fetch_count_d = fetch_count_q;
        state_d       = state_q;

        if (!rst) begin
            cache_en    = redirect_valid | ~stall_s;
            fetch_valid = resp_valid_q & ~redirect_valid;
            if (redirect_valid) begin
                cache_pc = redirect_pc;
            end else if (stall_s) begin
                cache_pc = req_pc_q;
            end else begin
                cache_pc = next_pc_q;
            end
            // A redirect target of PC_MAX is not a sequential wrap.
            pc_wrap = cache_en & ~redirect_valid & (next_pc_q == PC_MAX);
        end else begin
            cache_en = 1'b0;
        end

        if (cache_en) begin
            req_pc_d     = cache_pc;
            next_pc_d    = cache_pc + PC_W'(1);
            resp_valid_d = 1'b1;
        end else begin
            req_pc_d = req_pc_q;
        end

        if (fetch_valid && skid_ready) begin
            fetch_count_d = fetch_count_q + CNT_W'(1);
        end else begin
            fetch_count_d = fetch_count_q;
        end

        case (state_q)
            S_IDLE:  state_d = S_RUN;
            S_RUN:   state_d = (stall_s && !redirect_valid) ? S_STALL : S_RUN;
            S_STALL: state_d = (skid_ready || redirect_valid) ? S_RUN : S_STALL;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset taking priority over all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            next_pc_q     <= {PC_W{1'b0}};
            req_pc_q      <= {PC_W{1'b0}};
            resp_valid_q  <= 1'b0;
            fetch_count_q <= {CNT_W{1'b0}};
            state_q       <= S_IDLE;
        end else begin
            next_pc_q     <= next_pc_d;
            req_pc_q      <= req_pc_d;
            resp_valid_q  <= resp_valid_d;
            fetch_count_q <= fetch_count_d;
            state_q       <= state_d;
        end
    end

    assign fetch_pc    = req_pc_q;
    assign fetch_instr = cache_instr;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: BRAM model, address-stream reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [8:0]  redirect_pc;
    logic        cache_en;
    logic [8:0]  cache_pc;
    logic [31:0] cache_instr = 32'h0;
    logic        skid_ready;
    logic        fetch_valid;
    logic [8:0]  fetch_pc;
    logic [31:0] fetch_instr;
    logic        pc_wrap;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [512];

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .cache_en(cache_en), .cache_pc(cache_pc), .cache_instr(cache_instr),
        .skid_ready(skid_ready),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
        .pc_wrap(pc_wrap), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction BRAM: 1-cycle read, output register holds while disabled.
    always @(posedge clk) begin
        if (cache_en === 1'b1) cache_instr <= mem[cache_pc];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the word on the BRAM output (if any), the next
    // sequential address, and the number of accepted instructions.
    bit          armed = 1'b0;
    bit          m_has;
    int          m_pc;
    int          m_seq;
    logic [31:0] m_cnt;

    function automatic void expect_now(output bit e_en, output int e_addr,
                                       output bit e_fv, output bit e_wrap);
        bit blocked;
        if (rst) begin
            e_en = 0; e_addr = 0; e_fv = 0; e_wrap = 0;
        end else begin
            blocked = m_has && !skid_ready;
            e_fv    = m_has && !redirect_valid;
            e_en    = redirect_valid || !blocked;
            if (redirect_valid)  e_addr = int'(redirect_pc);
            else if (blocked)    e_addr = m_pc;
            else                 e_addr = m_seq;
            e_wrap  = e_en && !redirect_valid && (m_seq == 511);
        end
    endfunction

    always @(posedge clk) begin
        bit e_en, e_fv, e_wrap;
        int e_addr;
        if (rst) begin
            armed = 1'b1;
            m_has = 0; m_pc = 0; m_seq = 0; m_cnt = 32'h0;
        end else if (armed) begin
            expect_now(e_en, e_addr, e_fv, e_wrap);
            if (e_fv && skid_ready) m_cnt = m_cnt + 32'h1;
            if (e_en) begin
                m_has = 1;
                m_pc  = e_addr;
                m_seq = (e_addr + 1) % 512;
            end
        end
    end

    always @(negedge clk) begin
        bit e_en, e_fv, e_wrap;
        int e_addr;
        if (armed) begin
            expect_now(e_en, e_addr, e_fv, e_wrap);
            chk("m_cache_en", {31'h0, cache_en}, {31'h0, e_en});
            chk("m_cache_pc", {23'h0, cache_pc}, 32'(e_addr));
            chk("m_fetch_valid", {31'h0, fetch_valid}, {31'h0, e_fv});
            chk("m_pc_wrap", {31'h0, pc_wrap}, {31'h0, e_wrap});
            chk("m_fetch_count", fetch_count, m_cnt);
            if (m_has && !rst) begin
                chk("m_fetch_pc", {23'h0, fetch_pc}, 32'(m_pc));
                chk("m_fetch_instr", fetch_instr, mem[m_pc]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h100 + 32'(i);
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 9'h0; skid_ready = 1'b1;
        repeat (10) tick();
        look();
        chk("rst_cache_en", {31'h0, cache_en}, 32'h0);
        chk("rst_fetch_valid", {31'h0, fetch_valid}, 32'h0);
        chk("rst_cache_pc", {23'h0, cache_pc}, 32'h0);

        tick(); rst = 1'b0;
        look();
        chk("first_issue_en", {31'h0, cache_en}, 32'h1);
        chk("first_issue_pc", {23'h0, cache_pc}, 32'h0);
        chk("first_issue_fv", {31'h0, fetch_valid}, 32'h0);
        tick(); look();
        chk("first_fv", {31'h0, fetch_valid}, 32'h1);
        chk("first_pc", {23'h0, fetch_pc}, 32'h0);
        chk("first_instr", fetch_instr, 32'h100);
        chk("first_cache_pc", {23'h0, cache_pc}, 32'h1);

        // Backpressure while pc 4 is on the output.
        repeat (4) tick();
        skid_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            look();
            chk("bp_cache_en", {31'h0, cache_en}, 32'h0);
            chk("bp_fetch_pc", {23'h0, fetch_pc}, 32'h4);
            chk("bp_instr", fetch_instr, 32'h104);
            chk("bp_count", fetch_count, 32'h4);
            tick();
        end
        skid_ready = 1'b1;
        look();
        chk("bp_release_pc", {23'h0, fetch_pc}, 32'h4);
        chk("bp_release_cache_pc", {23'h0, cache_pc}, 32'h5);
        tick(); look();
        chk("bp_next_pc", {23'h0, fetch_pc}, 32'h5);
        chk("count5", fetch_count, 32'h5);

        // Redirect while running at pc 7.
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 9'h040;
        look();
        chk("rd_fv", {31'h0, fetch_valid}, 32'h0);
        chk("rd_cache_pc", {23'h0, cache_pc}, 32'h40);
        chk("rd_old_pc", {23'h0, fetch_pc}, 32'h7);
        tick(); redirect_valid = 1'b0;
        look();
        chk("rd_new_pc", {23'h0, fetch_pc}, 32'h40);
        chk("rd_new_fv", {31'h0, fetch_valid}, 32'h1);
        chk("rd_count", fetch_count, 32'h7);
        tick(); look();
        chk("rd_seq_pc", {23'h0, fetch_pc}, 32'h41);
        chk("rd_seq_count", fetch_count, 32'h8);

        // Redirect while stalled.
        tick(); redirect_valid = 1'b1; redirect_pc = 9'h010;
        tick(); redirect_valid = 1'b0; skid_ready = 1'b0;
        look();
        chk("st_pc", {23'h0, fetch_pc}, 32'h10);
        chk("st_cache_en", {31'h0, cache_en}, 32'h0);
        tick(); redirect_valid = 1'b1; redirect_pc = 9'h020;
        look();
        chk("st_rd_fv", {31'h0, fetch_valid}, 32'h0);
        chk("st_rd_en", {31'h0, cache_en}, 32'h1);
        chk("st_rd_cache_pc", {23'h0, cache_pc}, 32'h20);
        tick(); redirect_valid = 1'b0;
        look();
        chk("st_new_pc", {23'h0, fetch_pc}, 32'h20);
        chk("st_new_fv", {31'h0, fetch_valid}, 32'h1);
        chk("st_count", fetch_count, 32'h9);
        tick(); skid_ready = 1'b1;
        tick(); look();
        chk("st_after_pc", {23'h0, fetch_pc}, 32'h21);
        chk("st_after_count", fetch_count, 32'hA);

        // Wrap at the top of the BRAM.
        tick(); redirect_valid = 1'b1; redirect_pc = 9'h1FD;
        look();
        chk("wr_rd_wrap", {31'h0, pc_wrap}, 32'h0);
        tick(); redirect_valid = 1'b0;
        look();
        chk("wr_pc_1fd", {23'h0, fetch_pc}, 32'h1FD);
        chk("wr_wrap0a", {31'h0, pc_wrap}, 32'h0);
        tick(); look();
        chk("wr_pc_1fe", {23'h0, fetch_pc}, 32'h1FE);
        chk("wr_cache_1ff", {23'h0, cache_pc}, 32'h1FF);
        chk("wr_wrap1", {31'h0, pc_wrap}, 32'h1);
        tick(); look();
        chk("wr_pc_1ff", {23'h0, fetch_pc}, 32'h1FF);
        chk("wr_instr_2ff", fetch_instr, 32'h2FF);
        chk("wr_cache_000", {23'h0, cache_pc}, 32'h0);
        chk("wr_wrap0b", {31'h0, pc_wrap}, 32'h0);
        tick(); look();
        chk("wr_pc_000", {23'h0, fetch_pc}, 32'h0);
        chk("wr_instr_100", fetch_instr, 32'h100);

        // Back-to-back redirects, including targets at the top of the BRAM.
        tick(); redirect_valid = 1'b1; redirect_pc = 9'h1FF;
        look();
        chk("bb_wrap_1ff", {31'h0, pc_wrap}, 32'h0);
        tick(); redirect_pc = 9'h1FE;
        look();
        chk("bb_cache_1fe", {23'h0, cache_pc}, 32'h1FE);
        tick(); redirect_pc = 9'h030;
        look();
        chk("bb_wrap_gate", {31'h0, pc_wrap}, 32'h0);
        chk("bb_fv", {31'h0, fetch_valid}, 32'h0);
        tick(); redirect_valid = 1'b0;
        look();
        chk("bb_last_wins", {23'h0, fetch_pc}, 32'h30);

        // Reset with a redirect and a stall both active.
        tick(); skid_ready = 1'b0;
        look();
        chk("rp_stall_en", {31'h0, cache_en}, 32'h0);
        tick(); rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 9'h055;
        look();
        chk("rp_en", {31'h0, cache_en}, 32'h0);
        chk("rp_fv", {31'h0, fetch_valid}, 32'h0);
        chk("rp_cache_pc", {23'h0, cache_pc}, 32'h0);
        tick(); rst = 1'b0; redirect_valid = 1'b0; skid_ready = 1'b1;
        look();
        chk("rp_count", fetch_count, 32'h0);
        chk("rp_after_fv", {31'h0, fetch_valid}, 32'h0);
        chk("rp_after_pc", {23'h0, cache_pc}, 32'h0);
        tick(); look();
        chk("rp_restart_pc", {23'h0, fetch_pc}, 32'h0);
        chk("rp_restart_instr", fetch_instr, 32'h100);
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front-end fetch stage of the OoO core. Generates sequential instruction-memory word addresses and drives the 512-word single-port instruction BRAM, which has 1-cycle read latency.
- Presents each {pc, instr} pair to the fetch→decode skid buffer with a valid/ready handshake.
- Accepts redirects (mispredict/flush) from the branch unit.
- Keeps a retired-fetch counter and a PC-wrap pulse for bench and debug use.

Parameters:
- PC_W, 9, width of PC. The PC is a word index into the instruction BRAM.
- INSTR_W, 32, instruction width.
- CNT_W, 32, width of the fetch counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- redirect_valid  in  1  flush in-flight fetch and restart at redirect_pc.
- redirect_pc  in  PC_W  restart word address.
- cache_en  out  1  BRAM enable. When low, the BRAM output register holds its value.
- cache_pc  out  PC_W  BRAM address (fetch_to_cache_pc).
- cache_instr  in  INSTR_W  BRAM read data, valid 1 cycle after an enabled address.
- skid_ready  in  1  skid buffer can accept.
- fetch_valid  out  1  fetch_to_skid_valid.
- fetch_pc  out  PC_W  fetch_to_skid_pc.
- fetch_instr  out  INSTR_W  fetch_to_skid_instr (equals cache_instr).
- pc_wrap  out  1  one-cycle pulse when sequential fetch issues address 0x1FF (next address wraps to 0x000).
- fetch_count  out  CNT_W  number of completed fetch handshakes.

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high. All state updates on posedge clk. rst has priority over every other input.
- Registers:
  - next_pc: next sequential address.
  - req_pc: PC of the data currently on cache_instr.
  - resp_valid: cache_instr holds a live instruction.
  - fetch_count.
  - state in {S_IDLE, S_RUN, S_STALL}.
- Reset values: next_pc=0, req_pc=0, resp_valid=0, fetch_count=0, state=S_IDLE. While rst=1, cache_en=0, cache_pc=0, fetch_valid=0, pc_wrap=0.
- Combinational terms:
  - stall = resp_valid & ~skid_ready.
  - fetch_valid = resp_valid & ~redirect_valid. A redirect squashes the instruction on the output that same cycle.
  - fetch_pc = req_pc; fetch_instr = cache_instr.
  - cache_en = redirect_valid | ~stall.
  - cache_pc = redirect_valid ? redirect_pc : (stall ? req_pc : next_pc).
  - pc_wrap = cache_en & ~redirect_valid & (next_pc == 2^PC_W-1) & ~rst.
- Update when cache_en=1 (and not rst):
  - req_pc <= cache_pc.
  - next_pc <= cache_pc+1, modulo 2^PC_W (0x1FF+1 = 0x000, no carry out).
  - resp_valid <= 1.
- Update when cache_en=0: all registers hold. The BRAM output holds because its enable is low, so fetch_instr stays stable while stalled.
- fetch_count increments by 1 on fetch_valid & skid_ready and wraps modulo 2^CNT_W. A handshake is never counted in a redirect cycle.
- States:
  - S_IDLE: entered from reset; resp_valid=0. The first cycle after rst falls issues cache_pc=0 → S_RUN. The first fetch_valid=1 (pc 0) appears 1 cycle after the first enabled address.
  - S_RUN: goes to S_STALL when stall & ~redirect_valid; otherwise stays.
  - S_STALL: goes to S_RUN on skid_ready or redirect_valid.
- Latency: 1 cycle from address issue to fetch_valid. Throughput is 1 instruction/cycle with skid_ready held high.
- Redirect rules:
  - Cost is exactly one bubble: fetch_valid=0 in redirect cycle N; fetch_valid=1 with fetch_pc=redirect_pc in N+1, if not reset.
  - A redirect during S_STALL drops the held instruction and is accepted regardless of skid_ready.
  - Back-to-back redirects: the last one wins; each cycle's redirect_pc is issued.
  - A redirect with redirect_pc=0x1FF gives no pc_wrap pulse. The subsequent sequential issue of 0x1FF does pulse.
- Reset mid-operation: resp_valid is cleared next cycle, no handshake completes in the reset cycle, and fetch restarts at 0.
- No X on any output after the first reset cycle. The outputs are fully combinational from registers and inputs, with no combinational path from cache_instr to control.

Test Plan:
- Reset (rst high 10 cycles, then low, skid_ready=1, BRAM preloaded with word i = 0x100+i) → cache_pc sequence 0,1,2,…; fetch_valid first high 1 cycle after release with fetch_pc=0, fetch_instr=0x100; fetch_count=5 after 5 valid cycles.
- Backpressure: skid_ready=0 for 3 cycles while fetch_pc=4 → cache_en=0, fetch_pc=4, fetch_instr=0x104 held all 3 cycles, fetch_count unchanged; on ready, next cycle fetch_pc=5, no skipped or duplicated PCs.
- Redirect in run: redirect_valid=1, redirect_pc=0x040 while fetch_pc=0x007 → fetch_valid=0 that cycle, cache_pc=0x040; next cycle fetch_pc=0x040, then 0x041; 0x007 not counted.
- Redirect while stalled (skid_ready=0, fetch_pc=0x010, redirect_pc=0x020) → held instruction dropped, cache_en=1; next cycle fetch_pc=0x020 with fetch_valid=1 even though skid_ready=0.
- Wrap: redirect to 0x1FD, stream → pc_wrap pulses exactly once, in the cycle cache_pc=0x1FF; the following cache_pc is 0x000 and fetch_pc sequence is 1FD, 1FE, 1FF, 000.
- Reset priority: assert rst with redirect_valid=1 and stall active → next cycle all registers at reset values, fetch_valid=0, fetch_count=0, cache_en=0.
